// File: rtl/led32x32_pkg.sv
// rtl/led32x32_pkg.sv - shared constants and state encodings for the 32x32 LED frame path
// Purpose: geometry constants of the LED frame and the FSM encodings used by
//          the frame loader (write side) and the row streamer (read side).
// Ports:   none (package)
package led32x32_pkg;

  localparam int LED_ROWS      = 32;
  localparam int BYTES_PER_ROW = 4;
  localparam int ROW_IDX_W     = 5;
  localparam int BYTE_IDX_W    = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2
  } loader_state_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } streamer_state_t;

endpackage

// File: rtl/led32x32_row_packer.sv
// rtl/led32x32_row_packer.sv - packs four bytes into one 32-bit LED row word
// Purpose: shifts accepted bytes into a row word in MSB-first or LSB-first
//          order and flags the byte that completes a row.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_clear           drop any partial row (new frame or cancel)
//   i_load            a byte is accepted this cycle
//   i_byte            the accepted byte
//   o_word            row word including the byte being accepted this cycle
//   o_word_complete   this accepted byte is the 4th of its row
module led32x32_row_packer
  import led32x32_pkg::*;
#(
  parameter bit BYTE_MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_complete
);

  logic [31:0]           r_word;
  logic [BYTE_IDX_W-1:0] r_byte_cnt;
  logic [31:0]           w_next_word;

  // MSB-first shifts left so byte 0 ends in [31:24]; LSB-first shifts right
  // so byte 0 ends in [7:0].
  always_comb begin
    if (BYTE_MSB_FIRST) begin
      w_next_word = {r_word[23:0], i_byte};
    end else begin
      w_next_word = {i_byte, r_word[31:8]};
    end
  end

  // The completed word is handed out combinationally so the write register
  // can capture it on the same edge that accepts the 4th byte.
  assign o_word          = w_next_word;
  assign o_word_complete = i_load && (r_byte_cnt == BYTE_IDX_W'(BYTES_PER_ROW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word     <= '0;
      r_byte_cnt <= '0;
    end else if (i_clear) begin
      r_word     <= '0;
      r_byte_cnt <= '0;
    end else if (i_load) begin
      r_word     <= w_next_word;
      r_byte_cnt <= r_byte_cnt + 1'b1;  // wraps to 0 after the 4th byte
    end
  end

endmodule

// File: rtl/led32x32_frame_loader.sv
// rtl/led32x32_frame_loader.sv - byte-stream to frame-BRAM loader for the 32x32 LED panel
// Purpose: accepts a 128-byte frame one byte per cycle, packs rows of four
//          bytes and writes the 32 rows to the frame BRAM at {frame, row}.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_start           begin a frame load (only while idle)
//   i_frame_sel       target frame slot, latched on an accepted start
//   i_abort           cancel the load in progress
//   i_in_valid        input byte valid
//   i_in_data         input byte
//   o_in_ready        byte accepted when i_in_valid && o_in_ready
//   o_bram_wr_en      one-cycle BRAM write strobe per row
//   o_bram_wr_addr    {frame_q, row_idx}
//   o_bram_wr_data    packed row word
//   o_busy            load in progress
//   o_done            one-cycle pulse after the last row is written
module led32x32_frame_loader
  import led32x32_pkg::*;
#(
  parameter int FRAME_SEL_WIDTH = 3,
  parameter bit BYTE_MSB_FIRST  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_start,
  input  logic [FRAME_SEL_WIDTH-1:0] i_frame_sel,
  input  logic                       i_abort,
  input  logic                       i_in_valid,
  input  logic [7:0]                 i_in_data,
  output logic                       o_in_ready,
  output logic                       o_bram_wr_en,
  output logic [FRAME_SEL_WIDTH+4:0] o_bram_wr_addr,
  output logic [31:0]                o_bram_wr_data,
  output logic                       o_busy,
  output logic                       o_done
);

  loader_state_t                r_state;
  loader_state_t                w_next_state;
  logic [FRAME_SEL_WIDTH-1:0]   r_frame_q;
  logic [ROW_IDX_W-1:0]         r_row_cnt;
  logic                         r_wr_en;
  logic [FRAME_SEL_WIDTH+4:0]   r_wr_addr;
  logic [31:0]                  r_wr_data;
  logic                         r_done;

  logic                         w_accept;
  logic                         w_start_ok;
  logic                         w_row_write;
  logic                         w_last_row;
  logic [31:0]                  w_word;
  logic                         w_word_complete;

  assign o_in_ready  = (r_state == S_LOAD);
  assign o_busy      = (r_state != S_IDLE);
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_start_ok  = (r_state == S_IDLE) && i_start && !i_abort;
  // A row completed in the abort cycle is dropped, not written.
  assign w_row_write = w_word_complete && !i_abort;
  assign w_last_row  = (r_row_cnt == ROW_IDX_W'(LED_ROWS - 1));

  led32x32_row_packer #(
    .BYTE_MSB_FIRST (BYTE_MSB_FIRST)
  ) u_packer (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_clear         (w_start_ok || i_abort),
    .i_load          (w_accept),
    .i_byte          (i_in_data),
    .o_word          (w_word),
    .o_word_complete (w_word_complete)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        if (i_abort)                       w_next_state = S_IDLE;
        else if (w_row_write && w_last_row) w_next_state = S_FLUSH;
      end
      S_FLUSH: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_q <= '0;
      r_row_cnt <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
    end else begin
      r_wr_en <= w_row_write;
      r_done  <= (r_state == S_FLUSH) && !i_abort;
      if (w_start_ok) begin
        r_frame_q <= i_frame_sel;
        r_row_cnt <= '0;
      end
      // Address/data only move on a write so they hold between strobes.
      if (w_row_write) begin
        r_wr_addr <= {r_frame_q, r_row_cnt};
        r_wr_data <= w_word;
        r_row_cnt <= r_row_cnt + 1'b1;
      end
    end
  end

  assign o_bram_wr_en   = r_wr_en;
  assign o_bram_wr_addr = r_wr_addr;
  assign o_bram_wr_data = r_wr_data;
  assign o_done         = r_done;

endmodule

// File: tb/tb_led32x32_frame_loader.sv
// tb/tb_led32x32_frame_loader.sv - scoreboard bench for the LED frame loader (MSB and LSB packing)
module tb_led32x32_frame_loader;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          due;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] frame_sel = 3'd0;
  logic [7:0] in_data = 8'd0;

  logic        m_ready, m_wr_en, m_busy, m_done;
  logic [7:0]  m_addr;
  logic [31:0] m_data;
  logic        l_ready, l_wr_en, l_busy, l_done;
  logic [7:0]  l_addr;
  logic [31:0] l_data;

  led32x32_frame_loader #(.FRAME_SEL_WIDTH(3), .BYTE_MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_frame_sel(frame_sel), .i_abort(abort),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(m_ready), .o_bram_wr_en(m_wr_en),
    .o_bram_wr_addr(m_addr), .o_bram_wr_data(m_data), .o_busy(m_busy), .o_done(m_done)
  );

  led32x32_frame_loader #(.FRAME_SEL_WIDTH(3), .BYTE_MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_frame_sel(frame_sel), .i_abort(abort),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(l_ready), .o_bram_wr_en(l_wr_en),
    .o_bram_wr_addr(l_addr), .o_bram_wr_data(l_data), .o_busy(l_busy), .o_done(l_done)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  bit         m_active = 1'b0;
  bit         m_flush = 1'b0;
  int         m_frame = 0;
  int         m_row = 0;
  int         m_nb = 0;
  logic [7:0] m_buf [4];
  int         done_due = -1;
  wr_t        q_msb[$];
  wr_t        q_lsb[$];
  logic [7:0] frame_bytes [128];
  int         n_tests = 0;
  int         n_fail = 0;
  bit         mon_on = 1'b0;
  int         done_cnt = 0;
  int         wr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a frame is 32 rows of 4 bytes; each completed row is
  // expected on the BRAM port in the cycle after its 4th byte is taken.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_active = 1'b0; m_flush = 1'b0; m_nb = 0; m_row = 0;
    end else if (!m_active) begin
      if (start && !abort) begin
        m_active = 1'b1; m_flush = 1'b0; m_frame = int'(frame_sel); m_row = 0; m_nb = 0;
      end
    end else if (m_flush) begin
      m_active = 1'b0; m_flush = 1'b0;
      if (!abort) done_due = cyc;
    end else if (abort) begin
      m_active = 1'b0;
    end else if (in_valid) begin
      m_buf[m_nb] = in_data;
      m_nb++;
      if (m_nb == 4) begin
        wr_t e;
        e.addr = 8'(m_frame * 32 + m_row);
        e.due  = cyc;
        e.data = {m_buf[0], m_buf[1], m_buf[2], m_buf[3]};
        q_msb.push_back(e);
        e.data = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
        q_lsb.push_back(e);
        m_nb = 0;
        m_row++;
        if (m_row == 32) m_flush = 1'b1;
      end
    end
  end

  task automatic mon_wr(input int id, input logic en, input logic [7:0] a, input logic [31:0] d);
    wr_t e;
    int  n;
    n = (id == 0) ? q_msb.size() : q_lsb.size();
    if (n > 0) e = (id == 0) ? q_msb[0] : q_lsb[0];
    if (en) begin
      n_tests++;
      if (n == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected[%0d] cyc=%0d got addr=%0h data=%0h expected no write", id, cyc, a, d);
      end else begin
        if (id == 0) void'(q_msb.pop_front()); else void'(q_lsb.pop_front());
        if (a !== e.addr || d !== e.data || cyc != e.due) begin
          n_fail++;
          $display("FAIL wr_row[%0d] cyc=%0d got addr=%0h data=%0h expected addr=%0h data=%0h at cyc=%0d",
                   id, cyc, a, d, e.addr, e.data, e.due);
        end
      end
    end else if (n > 0 && e.due <= cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL wr_missing[%0d] cyc=%0d got no write expected addr=%0h data=%0h", id, cyc, e.addr, e.data);
      if (id == 0) void'(q_msb.pop_front()); else void'(q_lsb.pop_front());
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_on) begin
      chk("in_ready_msb", 32'(m_ready), 32'(m_active && !m_flush));
      chk("in_ready_lsb", 32'(l_ready), 32'(m_active && !m_flush));
      chk("busy_msb", 32'(m_busy), 32'(m_active));
      chk("busy_lsb", 32'(l_busy), 32'(m_active));
      chk("done_msb", 32'(m_done), 32'(done_due == cyc));
      chk("done_lsb", 32'(l_done), 32'(done_due == cyc));
      mon_wr(0, m_wr_en, m_addr, m_data);
      mon_wr(1, l_wr_en, l_addr, l_data);
      if (m_done) done_cnt++;
      if (m_wr_en) wr_cnt++;
    end
  end

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    m_active = 1'b0; m_flush = 1'b0; m_nb = 0; m_row = 0; done_due = -1;
    q_msb.delete();
    q_lsb.delete();
    #1;
    chk("rst_ready_msb", 32'(m_ready), 0);  chk("rst_ready_lsb", 32'(l_ready), 0);
    chk("rst_wr_en_msb", 32'(m_wr_en), 0);  chk("rst_wr_en_lsb", 32'(l_wr_en), 0);
    chk("rst_addr_msb", 32'(m_addr), 0);    chk("rst_addr_lsb", 32'(l_addr), 0);
    chk("rst_data_msb", m_data, 0);         chk("rst_data_lsb", l_data, 0);
    chk("rst_busy_msb", 32'(m_busy), 0);    chk("rst_busy_lsb", 32'(l_busy), 0);
    chk("rst_done_msb", 32'(m_done), 0);    chk("rst_done_lsb", 32'(l_done), 0);
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic do_start(input logic [2:0] fs);
    start = 1'b1;
    frame_sel = fs;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_frame(input int gap, input bit toggle, input int abort_at, input int stop_at);
    int guard;
    int idx;
    bit quit;
    guard = 0;
    quit = 1'b0;
    while (m_active && !m_flush && !quit) begin
      idx = m_row * 4 + m_nb;
      if (idx == stop_at) begin
        quit = 1'b1;
      end else begin
        in_valid = (int'($urandom_range(99)) >= gap);
        in_data  = frame_bytes[idx];
        if (toggle) begin
          start     = 1'($urandom_range(1));
          frame_sel = 3'($urandom);
        end
        if (idx == abort_at) begin
          abort    = 1'b1;
          in_valid = (abort_at % 4 == 3);
        end
        @(posedge clk);
        #1;
        abort = 1'b0;
        guard++;
        if (guard > 2000) begin
          chk("load_timeout", 1, 0);
          quit = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (m_active && g < 300) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (m_active) chk("idle_timeout", 1, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic fill(input bit rnd);
    for (int i = 0; i < 128; i++) frame_bytes[i] = rnd ? 8'($urandom) : 8'(i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got no finish expected finish", cyc);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset(2);
    mon_on = 1'b1;

    // counting frame into slot 3, back-to-back then with gaps
    fill(1'b0);
    done_cnt = 0; wr_cnt = 0;
    do_start(3'd3);
    send_frame(0, 1'b0, -1, -1);
    wait_idle();
    chk("t1_done_count", done_cnt, 1);
    chk("t1_write_count", wr_cnt, 32);
    done_cnt = 0; wr_cnt = 0;
    do_start(3'd3);
    send_frame(40, 1'b0, -1, -1);
    wait_idle();
    chk("t2_done_count", done_cnt, 1);
    chk("t2_write_count", wr_cnt, 32);

    // packing order with a known first row
    fill(1'b1);
    frame_bytes[0] = 8'h11; frame_bytes[1] = 8'h22; frame_bytes[2] = 8'h33; frame_bytes[3] = 8'h44;
    do_start(3'($urandom));
    send_frame(20, 1'b0, -1, -1);
    wait_idle();

    // abort after 10 bytes, then a fresh load into slot 1
    fill(1'b1);
    done_cnt = 0; wr_cnt = 0;
    do_start(3'd5);
    send_frame(0, 1'b0, 10, -1);
    wait_idle();
    chk("t4_abort_writes", wr_cnt, 2);
    chk("t4_abort_no_done", done_cnt, 0);
    fill(1'b1);
    do_start(3'd1);
    send_frame(25, 1'b0, -1, -1);
    wait_idle();

    // start together with abort while idle starts nothing
    start = 1'b1; abort = 1'b1; frame_sel = 3'd4;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // start/frame_sel noise during a load; abort on the 4th byte of row 6
    fill(1'b1);
    done_cnt = 0; wr_cnt = 0;
    do_start(3'd7);
    send_frame(30, 1'b1, 27, -1);
    wait_idle();
    chk("t5_abort_writes", wr_cnt, 6);
    chk("t5_abort_no_done", done_cnt, 0);
    fill(1'b1);
    do_start(3'd2);
    send_frame(30, 1'b1, -1, -1);
    wait_idle();

    // reset in the middle of row 1, then a clean full load
    fill(1'b1);
    do_start(3'd4);
    send_frame(0, 1'b0, -1, 6);
    do_reset(2);
    fill(1'b1);
    do_start(3'd6);
    send_frame(10, 1'b0, -1, -1);
    wait_idle();

    for (int k = 0; k < 3; k++) begin
      fill(1'b1);
      do_start(3'($urandom));
      send_frame(int'($urandom_range(60)), 1'(k), -1, -1);
      wait_idle();
    end

    chk("pending_msb", q_msb.size(), 0);
    chk("pending_lsb", q_lsb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
